// File: rtl/multicycle_control_if.sv
// Shared-memory handshake between the multicycle controller and the memory port.
// The controller drives the request and read/write select; memory answers with ready.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle RV32I-subset datapath with variable-latency memory,
// illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [3:0]           state,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             stall;
  logic             done;

  logic             mem_req_q, mem_we_q, i_or_d_q;
  logic             pc_write_cond_q, pc_src_q, alu_src_a_q;
  logic [1:0]       alu_src_b_q, alu_op_q;
  logic             reg_write_q, mem_to_reg_q, halted_q;

  // Branch resolution happens in the datapath, which gates pc_write_cond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  // mem_req_q is 0 during reset and the partial cycle after release, so a
  // ready seen before the first real request is never taken as a handshake.
  assign done  = mem_req_q & mem.mem_ready;
  assign stall = mem_req_q & ~mem.mem_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    retire  = 1'b0;

    case (state_q)
      S_FETCH:     if (done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (done) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase

    if (stall) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_TRAP;
        cause_d = 2'b10;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end

    if (state_d != state_q) wait_d = '0;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_FETCH;
      wait_q          <= '0;
      cause_q         <= '0;
      retired_q       <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      i_or_d_q        <= 1'b0;
      pc_write_cond_q <= 1'b0;
      pc_src_q        <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= '0;
      alu_op_q        <= '0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      if (retire) retired_q <= retired_q + 1'b1;

      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      i_or_d_q        <= 1'b0;
      pc_write_cond_q <= 1'b0;
      pc_src_q        <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= 2'b00;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      halted_q        <= 1'b0;

      case (state_d)
        S_FETCH: begin
          mem_req_q   <= 1'b1;
          alu_src_b_q <= 2'b01;
        end
        S_DECODE:    alu_src_b_q <= 2'b11;
        S_MEM_ADDR: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'b10;
        end
        S_MEM_READ: begin
          mem_req_q <= 1'b1;
          i_or_d_q  <= 1'b1;
        end
        S_MEM_WB: begin
          reg_write_q  <= 1'b1;
          mem_to_reg_q <= 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req_q <= 1'b1;
          mem_we_q  <= 1'b1;
          i_or_d_q  <= 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_q <= 1'b1;
          alu_op_q    <= 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'b10;
          alu_op_q    <= 2'b10;
        end
        S_ALU_WB:    reg_write_q <= 1'b1;
        S_BRANCH: begin
          alu_src_a_q     <= 1'b1;
          alu_op_q        <= 2'b01;
          pc_write_cond_q <= 1'b1;
          pc_src_q        <= 1'b1;
        end
        S_TRAP:      halted_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.i_or_d    = i_or_d_q;

  assign ir_write      = (state_q == S_FETCH) & done;
  assign pc_write      = (state_q == S_FETCH) & done;
  assign pc_write_cond = pc_write_cond_q;
  assign pc_src        = pc_src_q;
  assign alu_src_a     = alu_src_a_q;
  assign alu_src_b     = alu_src_b_q;
  assign alu_op        = alu_op_q;
  assign reg_write     = reg_write_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign state         = state_q;
  assign halted        = halted_q;
  assign trap_cause    = cause_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed corner cases plus a random
// instruction stream, checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 16;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MREAD = 3, ST_MWB = 4,
                 ST_MWRITE = 5, ST_EXR = 6, ST_EXI = 7, ST_ALUWB = 8, ST_BR = 9, ST_TRAP = 15;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;

  typedef struct packed {
    logic       req, we, iord, irw, pcw, pcwc, pcsrc, a;
    logic [1:0] b, op;
    logic       rw, m2r, halt;
  } outs_t;

  typedef struct {
    int   st;
    logic rdy;
  } step_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          ir_write, pc_write, pc_write_cond, pc_src, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          reg_write, mem_to_reg, halted;
  logic [3:0]    state;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instr_retired;

  multicycle_control_if mif();

  multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state), .halted(halted),
    .trap_cause(trap_cause), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  outs_t obs;
  assign obs = '{req: mif.mem_req, we: mif.mem_we, iord: mif.i_or_d, irw: ir_write,
                 pcw: pc_write, pcwc: pc_write_cond, pcsrc: pc_src, a: alu_src_a,
                 b: alu_src_b, op: alu_op, rw: reg_write, m2r: mem_to_reg, halt: halted};

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_ret = '0;

  // Control strobes each state must present, transcribed from the state table.
  function automatic outs_t spec_outs(input int st, input logic rdy);
    outs_t o = '0;
    case (st)
      ST_FETCH:  begin o.req = 1'b1; o.b = 2'b01; o.irw = rdy; o.pcw = rdy; end
      ST_DECODE: o.b = 2'b11;
      ST_MADDR:  begin o.a = 1'b1; o.b = 2'b10; end
      ST_MREAD:  begin o.req = 1'b1; o.iord = 1'b1; end
      ST_MWB:    begin o.rw = 1'b1; o.m2r = 1'b1; end
      ST_MWRITE: begin o.req = 1'b1; o.we = 1'b1; o.iord = 1'b1; end
      ST_EXR:    begin o.a = 1'b1; o.op = 2'b10; end
      ST_EXI:    begin o.a = 1'b1; o.b = 2'b10; o.op = 2'b10; end
      ST_ALUWB:  o.rw = 1'b1;
      ST_BR:     begin o.a = 1'b1; o.op = 2'b01; o.pcwc = 1'b1; o.pcsrc = 1'b1; end
      ST_TRAP:   o.halt = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [6:0] kind_opcode(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive ready mid-cycle, check the state and strobes, then take the edge.
  task automatic cyc(input int st, input logic rdy, input string tag);
    @(negedge clk);
    mif.mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".outs"}, 32'(obs), 32'(spec_outs(st, rdy)));
    chk({tag, ".retired"}, 32'(instr_retired), 32'(exp_ret));
    @(posedge clk);
  endtask

  // Builds the expected cycle trace of one instruction from its class and stall counts.
  task automatic run_instr(input int kind, input int stall_f, input int stall_m, input string tag);
    step_t q[$];
    opcode = kind_opcode(kind);
    zero   = 1'($urandom_range(0, 1));
    repeat (stall_f) q.push_back('{ST_FETCH, 1'b0});
    q.push_back('{ST_FETCH, 1'b1});
    q.push_back('{ST_DECODE, 1'($urandom_range(0, 1))});
    case (kind)
      K_R: begin
        q.push_back('{ST_EXR, 1'($urandom_range(0, 1))});
        q.push_back('{ST_ALUWB, 1'($urandom_range(0, 1))});
      end
      K_I: begin
        q.push_back('{ST_EXI, 1'($urandom_range(0, 1))});
        q.push_back('{ST_ALUWB, 1'($urandom_range(0, 1))});
      end
      K_LD: begin
        q.push_back('{ST_MADDR, 1'($urandom_range(0, 1))});
        repeat (stall_m) q.push_back('{ST_MREAD, 1'b0});
        q.push_back('{ST_MREAD, 1'b1});
        q.push_back('{ST_MWB, 1'($urandom_range(0, 1))});
      end
      K_ST: begin
        q.push_back('{ST_MADDR, 1'($urandom_range(0, 1))});
        repeat (stall_m) q.push_back('{ST_MWRITE, 1'b0});
        q.push_back('{ST_MWRITE, 1'b1});
      end
      default: q.push_back('{ST_BR, 1'($urandom_range(0, 1))});
    endcase
    foreach (q[i]) cyc(q[i].st, q[i].rdy, tag);
    exp_ret = exp_ret + 1'b1;
    #1;
    chk({tag, ".retired_end"}, 32'(instr_retired), 32'(exp_ret));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    mif.mem_ready = 1'b1;
    exp_ret = '0;
    #1;
    chk({tag, ".rst_state"}, 32'(state), 32'(ST_FETCH));
    chk({tag, ".rst_outs"}, 32'(obs), 32'h0);
    chk({tag, ".rst_cause"}, 32'(trap_cause), 32'h0);
    chk({tag, ".rst_retired"}, 32'(instr_retired), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset0");

    run_instr(K_R, 0, 0, "add");
    run_instr(K_LD, 0, 3, "lw_stall3");
    run_instr(K_BR, 0, 0, "beq");
    run_instr(K_ST, 0, 2, "sw_stall2");
    run_instr(K_I, 1, 0, "addi");

    // Boundary: ready arriving on the last allowed stalled cycle wins over the timeout.
    run_instr(K_R, int'(TO) - 1, 0, "fetch_stall_limit");
    run_instr(K_LD, 0, int'(TO) - 1, "lw_stall_limit");
    run_instr(K_ST, 2, int'(TO) - 1, "sw_stall_limit");

    // Random stream, long enough to wrap the narrow retire counter.
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), "rand");
    end

    // Illegal opcode traps after DECODE and stays halted without requesting memory.
    opcode = 7'b1111111;
    cyc(ST_FETCH, 1'b1, "ill");
    cyc(ST_DECODE, 1'b1, "ill");
    for (int i = 0; i < 4; i++) begin
      cyc(ST_TRAP, 1'($urandom_range(0, 1)), "ill_trap");
      chk("ill_cause", 32'(trap_cause), 32'h1);
    end
    do_reset("ill_recover");
    run_instr(K_R, 0, 0, "post_ill");

    // Fetch timeout: the limit-th stalled cycle without ready traps.
    for (int i = 0; i < int'(TO); i++) cyc(ST_FETCH, 1'b0, "to_fetch");
    for (int i = 0; i < 3; i++) begin
      cyc(ST_TRAP, 1'($urandom_range(0, 1)), "to_trap");
      chk("to_cause", 32'(trap_cause), 32'h2);
    end
    do_reset("to_recover");

    // Timeout inside a load's memory read; the instruction does not retire.
    run_instr(K_I, 0, 0, "pre_ld_to");
    opcode = kind_opcode(K_LD);
    cyc(ST_FETCH, 1'b1, "ld_to");
    cyc(ST_DECODE, 1'b0, "ld_to");
    cyc(ST_MADDR, 1'b1, "ld_to");
    for (int i = 0; i < int'(TO); i++) cyc(ST_MREAD, 1'b0, "ld_to");
    cyc(ST_TRAP, 1'b1, "ld_to_trap");
    chk("ld_to_cause", 32'(trap_cause), 32'h2);
    do_reset("ld_to_recover");

    // Reset arriving mid-MEM_WRITE clears outputs immediately and restarts at FETCH.
    run_instr(K_R, 0, 0, "pre_sw");
    opcode = kind_opcode(K_ST);
    cyc(ST_FETCH, 1'b1, "sw_abort");
    cyc(ST_DECODE, 1'b0, "sw_abort");
    cyc(ST_MADDR, 1'b0, "sw_abort");
    cyc(ST_MWRITE, 1'b0, "sw_abort");
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    exp_ret = '0;
    #1;
    chk("abort_state", 32'(state), 32'(ST_FETCH));
    chk("abort_outs", 32'(obs), 32'h0);
    chk("abort_retired", 32'(instr_retired), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_req", 32'(mif.mem_req), 32'h1);
    chk("restart_iord", 32'(mif.i_or_d), 32'h0);
    chk("restart_retired", 32'(instr_retired), 32'h0);
    run_instr(K_ST, 0, 1, "post_abort_sw");
    run_instr(K_BR, 0, 0, "post_abort_br");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
